// File: rtl/sar_adc_controller_pkg.sv
// Shared definitions for the SAR ADC controller: FSM state encoding and default ladder width.
package sar_adc_controller_pkg;

  localparam int ADC_WIDTH = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_ACCUM  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    DECIDE = ST_DECIDE,
    ACCUM  = ST_ACCUM
  } sar_state_t;

endpackage

// File: rtl/sar_adc_controller_settle_timer.sv
// Reloadable settle downcounter: after load, done is high in the PERIOD-th following cycle.
module settle_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(PERIOD + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(PERIOD);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  // Flags the cycle whose edge takes the count to zero, so the caller leaves on time.
  assign done = (count == CW'(1)) && !load;

endmodule

// File: rtl/sar_adc_controller.sv
// Successive-approximation ADC controller: binary-searches an R2R ladder against an external
// comparator and optionally averages 2**AVG_LOG2 conversions per request.
module sar_adc_controller
  import sar_adc_controller_pkg::*;
#(
  parameter int WIDTH         = ADC_WIDTH,
  parameter int SETTLE_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2,
  parameter int AVG_LOG2      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             comp_in,
  output logic [WIDTH-1:0] R2R_out,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  if (WIDTH < 2) begin : g_bad_width
    $error("sar_adc_controller: WIDTH must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sar_adc_controller: SYNC_STAGES must be >= 2");
  end
  if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_settle
    $error("sar_adc_controller: SETTLE_CYCLES must be >= SYNC_STAGES+1");
  end
  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
    $error("sar_adc_controller: AVG_LOG2 must be in 0..4");
  end

  localparam int BW    = $clog2(WIDTH);
  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [BW-1:0]    TOP_BIT  = BW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_N   = CNT_W'((1 << AVG_LOG2) - 1);

  sar_state_t       state;
  logic [WIDTH-1:0] code;
  logic [WIDTH-1:0] code_decided;
  logic [BW-1:0]    bit_idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] n;
  logic [SYNC_STAGES-1:0] sync;
  logic             comp_s;
  logic             timer_load;
  logic             timer_done;

  // comp_in is asynchronous to clk; only the last synchroniser stage is ever looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], comp_in};
    end
  end
  assign comp_s = sync[SYNC_STAGES-1];

  assign timer_load = (state == IDLE   && start)
                   || (state == DECIDE && bit_idx != '0)
                   || (state == ACCUM  && n != LAST_N);

  settle_timer #(
    .PERIOD(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .done (timer_done)
  );

  // Commit the current trial bit and, unless it was the LSB, raise the next one.
  always_comb begin
    code_decided = code;
    code_decided[bit_idx] = comp_s;
    if (bit_idx != '0) begin
      code_decided[bit_idx - BW'(1)] = 1'b1;
    end
  end

  assign acc_sum = acc + ACC_W'(code);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      code    <= '0;
      bit_idx <= '0;
      acc     <= '0;
      n       <= '0;
      result  <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            code    <= MSB_CODE;
            bit_idx <= TOP_BIT;
            acc     <= '0;
            n       <= '0;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_done) begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          code <= code_decided;
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - BW'(1);
            state   <= SETTLE;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_sum;
          if (n == LAST_N) begin
            result <= WIDTH'(acc_sum >> AVG_LOG2);
            valid  <= 1'b1;
            code   <= '0;
            state  <= IDLE;
          end else begin
            n       <= n + CNT_W'(1);
            code    <= MSB_CODE;
            bit_idx <= TOP_BIT;
            state   <= SETTLE;
          end
        end
        default: begin
          code  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign R2R_out = busy ? code : '0;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed bench for sar_adc_controller: comparator model lags the ladder by two clocks.
module tb_sar_adc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       comp_in;
  logic       comp2;
  logic [7:0] r2r_out, r2r2;
  logic       busy, busy2, valid, valid2;
  logic [7:0] result, result2;

  logic [7:0] vin = 8'h00;
  logic [7:0] vin2 = 8'h00;
  logic       d1 = 1'b0, d2 = 1'b0, e1 = 1'b0, e2 = 1'b0;
  logic       glitch = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sar_adc_controller #(
    .WIDTH(8), .SETTLE_CYCLES(4), .SYNC_STAGES(2), .AVG_LOG2(0)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .comp_in(comp_in),
    .R2R_out(r2r_out), .busy(busy), .valid(valid), .result(result)
  );

  sar_adc_controller #(
    .WIDTH(8), .SETTLE_CYCLES(4), .SYNC_STAGES(2), .AVG_LOG2(2)
  ) u_avg (
    .clk(clk), .reset(reset), .start(start2), .comp_in(comp2),
    .R2R_out(r2r2), .busy(busy2), .valid(valid2), .result(result2)
  );

  // Comparator with two clocks of analog/pin delay; glitch inverts it to mimic ringing.
  always @(posedge clk) begin
    d1 <= (vin >= r2r_out);
    d2 <= d1;
    e1 <= (vin2 >= r2r2);
    e2 <= e1;
  end
  assign comp_in = d2 ^ glitch;
  assign comp2   = e2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Code on the ladder while bit b is under trial: bits above b from vin, bit b set.
  function automatic logic [7:0] trial(input logic [7:0] v, input int b);
    logic [7:0] mask;
    logic [7:0] one;
    mask = 8'hFF;
    mask = mask << (b + 1);
    one  = 8'h01;
    return (v & mask) | (one << b);
  endfunction

  task automatic conv1(input logic [7:0] v, input bit glitchy, input string tag);
    int cyc;
    bit busy_ok;
    vin = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (cyc < 60) begin
      glitch = glitchy && (cyc <= 40) && (((cyc - 1) % 5) != 2);
      if (cyc <= 40 && (cyc % 5) == 0) chk({tag, "_trial"}, 32'(r2r_out), 32'(trial(v, 8 - cyc / 5)));
      if (valid) break;
      if (!busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    glitch = 1'b0;
    chk({tag, "_latency"}, cyc, 42);
    chk({tag, "_result"}, 32'(result), 32'(v));
    chk({tag, "_busy_at_valid"}, 32'(busy), 0);
    chk({tag, "_busy_during"}, 32'(busy_ok), 1);
    tick();
    chk({tag, "_valid_pulse"}, 32'(valid), 0);
    $display("conv %s vin=%02h result=%02h latency=%0d", tag, v, result, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nv;
    int bad_busy;
    int vcyc;
    logic [7:0] vres;
    bit late_busy;

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_r2r", 32'(r2r_out), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_avg_busy", 32'(busy2), 0);
    chk("rst_avg_result", 32'(result2), 0);
    $display("reset busy=%0b r2r=%02h valid=%0b result=%02h", busy, r2r_out, valid, result);
    reset = 1'b0;
    tick();

    conv1(8'hA5, 1'b0, "a5");
    conv1(8'h00, 1'b0, "zero");
    conv1(8'hFF, 1'b0, "full");
    conv1(8'hC3, 1'b1, "glitch");

    // start held high: a new conversion is accepted in every valid cycle.
    vin = 8'h3C;
    start = 1'b1;
    tick();
    cyc = 1;
    nv = 0;
    bad_busy = 0;
    while (cyc <= 130) begin
      if (valid) begin
        nv++;
        chk("b2b_cycle", cyc, 42 * nv);
        chk("b2b_result", 32'(result), 32'h3C);
        $display("b2b valid %0d at cycle %0d result=%02h", nv, cyc, result);
      end else if (!busy) begin
        bad_busy++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("b2b_count", nv, 3);
    chk("b2b_busy_gaps", bad_busy, 0);
    for (int i = 0; i < 60 && busy; i++) tick();
    chk("b2b_idle", 32'(busy), 0);

    // Reset at cycle 20 of a conversion.
    vin = 8'h77;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_r2r", 32'(r2r_out), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_result", 32'(result), 0);
    $display("midrst busy=%0b r2r=%02h valid=%0b result=%02h", busy, r2r_out, valid, result);
    reset = 1'b0;
    tick();
    conv1(8'h5A, 1'b0, "post_reset");

    // Averaging instance: four conversions of 0x40/0x43/0x40/0x43.
    vin2 = 8'h40;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 1;
    nv = 0;
    vcyc = 0;
    vres = 8'h00;
    late_busy = 1'b0;
    while (cyc <= 220) begin
      if (cyc == 42 || cyc == 124) vin2 = 8'h43;
      else if (cyc == 83) vin2 = 8'h40;
      start2 = (cyc == 50 || cyc == 100);
      if (valid2) begin
        nv++;
        vcyc = cyc;
        vres = result2;
      end
      if (cyc > 165 && busy2) late_busy = 1'b1;
      tick();
      cyc++;
    end
    start2 = 1'b0;
    chk("avg_valid_count", nv, 1);
    chk("avg_latency", vcyc, 165);
    chk("avg_result", 32'(vres), 32'h41);
    chk("avg_no_queue", 32'(late_busy), 0);
    $display("avg valids=%0d at cycle %0d result=%02h", nv, vcyc, vres);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
